pipe_ctrl: RTL and testbench

Pipeline control unit for the 5-stage RISC-V core. Takes the redirect request (jump_flag/jump_addr) and the load-use hazard (hold_risk) from the EX stage, plus a memory-busy hold from MEM. Sequences per-stage hold/flush, drives the PC redirect and keeps stall/redirect statistics. Sits beside the pipeline registers. Sole source of their hold/flush controls.

---
 rtl/pipe_ctrl_if.sv | 48 ++++
 rtl/pipe_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_pipe_ctrl.sv | 377 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_if
// Groups the pipeline-control signals exchanged between the EX/MEM stages,
// the pipeline registers and pipe_ctrl.
//   slave  : the pipe_ctrl side (takes requests, drives hold/flush/redirect/stats)
//   master : the pipeline side (raises requests, consumes hold/flush/redirect/stats)
// Signals:
//   jump_flag_i / jump_addr_i : EX redirect request and its target
//   hold_risk_i               : EX load-use hazard
//   hold_mem_i                : MEM busy, freeze whole pipe
//   hold_*_o / flush_*_o      : per-stage register hold and NOP-load controls
//   pc_jump_o / pc_jump_addr_o: PC redirect strobe and target
//   mem_timeout_o             : sticky memory-hold timeout error
//   stall_cnt_o / redirect_cnt_o : statistics
//   state_o                   : control FSM state, debug
// -----------------------------------------------------------------------------
interface pipe_ctrl_if;
    logic        jump_flag_i;
    logic [31:0] jump_addr_i;
    logic        hold_risk_i;
    logic        hold_mem_i;
    logic        hold_pc_o;
    logic        hold_if_id_o;
    logic        hold_id_ex_o;
    logic        hold_ex_mem_o;
    logic        flush_if_id_o;
    logic        flush_id_ex_o;
    logic        pc_jump_o;
    logic [31:0] pc_jump_addr_o;
    logic        mem_timeout_o;
    logic [31:0] stall_cnt_o;
    logic [31:0] redirect_cnt_o;
    logic [1:0]  state_o;

    modport slave (
        input  jump_flag_i, jump_addr_i, hold_risk_i, hold_mem_i,
        output hold_pc_o, hold_if_id_o, hold_id_ex_o, hold_ex_mem_o,
        output flush_if_id_o, flush_id_ex_o, pc_jump_o, pc_jump_addr_o,
        output mem_timeout_o, stall_cnt_o, redirect_cnt_o, state_o
    );

    modport master (
        output jump_flag_i, jump_addr_i, hold_risk_i, hold_mem_i,
        input  hold_pc_o, hold_if_id_o, hold_id_ex_o, hold_ex_mem_o,
        input  flush_if_id_o, flush_id_ex_o, pc_jump_o, pc_jump_addr_o,
        input  mem_timeout_o, stall_cnt_o, redirect_cnt_o, state_o
    );
endinterface

// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl
// Pipeline control unit for the 5-stage RISC-V core. Resolves, in priority
// order, a MEM-busy freeze, an EX redirect and an EX load-use hazard into the
// per-stage hold/flush controls and the PC redirect, and keeps stall/redirect
// statistics plus a sticky memory-hold timeout flag.
// Ports:
//   clk     : core clock, rising edge
//   arst_n  : asynchronous active-low reset; forces every output to 0
//   bus     : pipe_ctrl_if.slave, all request/control/statistic signals
// Parameters:
//   FLUSH_EXTRA : cycles flush_if_id_o stays high after a redirect (0..7)
//   LU_CYCLES   : bubble cycles per load-use hazard (1..7)
//   MEM_TIMEOUT : consecutive hold_mem_i cycles that raise mem_timeout_o
// Control outputs are combinational from state and inputs (zero latency);
// counters, state and the timeout flag are registers.
// -----------------------------------------------------------------------------
module pipe_ctrl #(
    parameter int unsigned FLUSH_EXTRA = 1,
    parameter int unsigned LU_CYCLES   = 1,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        arst_n,
    pipe_ctrl_if.slave  bus
);

    // Mem-wait counter is at least 8 bits, wider if the timeout needs it.
    localparam int unsigned MW_RAW = $clog2(MEM_TIMEOUT + 1);
    localparam int unsigned MW     = (MW_RAW < 8) ? 8 : MW_RAW;

    localparam logic [2:0]    FLUSH_LOAD  = 3'(FLUSH_EXTRA);
    localparam logic [2:0]    LU_LOAD     = 3'(LU_CYCLES - 1);
    localparam logic [MW-1:0] TIMEOUT_VAL = MW'(MEM_TIMEOUT);
    localparam logic [MW-1:0] WAIT_MAX    = {MW{1'b1}};

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_FLUSH  = 2'd1,
        ST_BUBBLE = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic [2:0]    r_cnt;
    logic [2:0]    w_next_cnt;
    logic [MW-1:0] r_mem_wait;
    logic [MW-1:0] w_mem_wait_inc;
    logic          r_mem_timeout;
    logic [31:0]   r_stall_cnt;
    logic [31:0]   r_redirect_cnt;

    logic          w_hold_pc;
    logic          w_hold_if_id;
    logic          w_hold_id_ex;
    logic          w_hold_ex_mem;
    logic          w_flush_if_id;
    logic          w_flush_id_ex;
    logic          w_pc_jump;
    logic [31:0]   w_jump_addr;

    // Saturating increment of the consecutive mem-hold counter.
    always_comb begin
        w_mem_wait_inc = r_mem_wait;
        if (r_mem_wait == WAIT_MAX) begin
            w_mem_wait_inc = r_mem_wait;
        end else begin
            w_mem_wait_inc = r_mem_wait + {{(MW-1){1'b0}}, 1'b1};
        end
    end

    // Next-state and control decode: mem hold > jump > load-use > state actions.
    always_comb begin
        w_next_state  = r_state;
        w_next_cnt    = r_cnt;
        w_hold_pc     = 1'b0;
        w_hold_if_id  = 1'b0;
        w_hold_id_ex  = 1'b0;
        w_hold_ex_mem = 1'b0;
        w_flush_if_id = 1'b0;
        w_flush_id_ex = 1'b0;
        w_pc_jump     = 1'b0;
        w_jump_addr   = 32'd0;

        if (bus.hold_mem_i) begin
            // EX is frozen and will re-present jump/hazard after release,
            // so state and counter simply hold.
            w_hold_pc     = 1'b1;
            w_hold_if_id  = 1'b1;
            w_hold_id_ex  = 1'b1;
            w_hold_ex_mem = 1'b1;
        end else if (bus.jump_flag_i) begin
            w_pc_jump     = 1'b1;
            w_jump_addr   = bus.jump_addr_i;
            w_flush_if_id = 1'b1;
            w_flush_id_ex = 1'b1;
            // A jump from any state (re)starts the wrong-path flush window.
            if (FLUSH_EXTRA > 0) begin
                w_next_state = ST_FLUSH;
                w_next_cnt   = FLUSH_LOAD;
            end else begin
                w_next_state = ST_RUN;
                w_next_cnt   = 3'd0;
            end
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (bus.hold_risk_i) begin
                        w_hold_pc     = 1'b1;
                        w_hold_if_id  = 1'b1;
                        w_flush_id_ex = 1'b1;
                        if (LU_CYCLES > 1) begin
                            w_next_state = ST_BUBBLE;
                            w_next_cnt   = LU_LOAD;
                        end else begin
                            w_next_state = ST_RUN;
                            w_next_cnt   = 3'd0;
                        end
                    end else begin
                        w_next_state = ST_RUN;
                        w_next_cnt   = 3'd0;
                    end
                end
                ST_BUBBLE: begin
                    // The hazard is already being served; hold_risk_i is ignored.
                    w_hold_pc     = 1'b1;
                    w_hold_if_id  = 1'b1;
                    w_flush_id_ex = 1'b1;
                    if (r_cnt <= 3'd1) begin
                        w_next_state = ST_RUN;
                        w_next_cnt   = 3'd0;
                    end else begin
                        w_next_state = ST_BUBBLE;
                        w_next_cnt   = r_cnt - 3'd1;
                    end
                end
                ST_FLUSH: begin
                    // ID holds a flushed NOP, so a hazard indication is bogus.
                    w_flush_if_id = 1'b1;
                    if (r_cnt <= 3'd1) begin
                        w_next_state = ST_RUN;
                        w_next_cnt   = 3'd0;
                    end else begin
                        w_next_state = ST_FLUSH;
                        w_next_cnt   = r_cnt - 3'd1;
                    end
                end
                default: begin
                    w_next_state = ST_RUN;
                    w_next_cnt   = 3'd0;
                end
            endcase
        end
    end

    // State, down-counter, mem-wait, timeout flag and statistics registers.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state        <= ST_RUN;
            r_cnt          <= 3'd0;
            r_mem_wait     <= {MW{1'b0}};
            r_mem_timeout  <= 1'b0;
            r_stall_cnt    <= 32'd0;
            r_redirect_cnt <= 32'd0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            if (bus.hold_mem_i) begin
                r_mem_wait <= w_mem_wait_inc;
                // Set at the edge that closes the MEM_TIMEOUT-th consecutive hold cycle.
                if (w_mem_wait_inc >= TIMEOUT_VAL) begin
                    r_mem_timeout <= 1'b1;
                end else begin
                    r_mem_timeout <= r_mem_timeout;
                end
            end else begin
                r_mem_wait    <= {MW{1'b0}};
                r_mem_timeout <= r_mem_timeout;
            end
            if (w_hold_pc) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end else begin
                r_stall_cnt <= r_stall_cnt;
            end
            if (w_pc_jump) begin
                r_redirect_cnt <= r_redirect_cnt + 32'd1;
            end else begin
                r_redirect_cnt <= r_redirect_cnt;
            end
        end
    end

    // Controls are gated by reset so nothing leaks out while arst_n is low.
    assign bus.hold_pc_o      = arst_n & w_hold_pc;
    assign bus.hold_if_id_o   = arst_n & w_hold_if_id;
    assign bus.hold_id_ex_o   = arst_n & w_hold_id_ex;
    assign bus.hold_ex_mem_o  = arst_n & w_hold_ex_mem;
    assign bus.flush_if_id_o  = arst_n & w_flush_if_id;
    assign bus.flush_id_ex_o  = arst_n & w_flush_id_ex;
    assign bus.pc_jump_o      = arst_n & w_pc_jump;
    assign bus.pc_jump_addr_o = arst_n ? w_jump_addr : 32'd0;
    assign bus.mem_timeout_o  = r_mem_timeout;
    assign bus.stall_cnt_o    = r_stall_cnt;
    assign bus.redirect_cnt_o = r_redirect_cnt;
    assign bus.state_o        = r_state;

endmodule

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl
// Self-checking bench for pipe_ctrl (FLUSH_EXTRA=1, LU_CYCLES=2, MEM_TIMEOUT=3).
// Each step drives inputs on the falling edge, pushes the expected control
// snapshot to a scoreboard queue, and pops/compares it mid-cycle.
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;

    logic clk;
    logic arst_n;

    pipe_ctrl_if u_if ();

    pipe_ctrl #(
        .FLUSH_EXTRA (1),
        .LU_CYCLES   (2),
        .MEM_TIMEOUT (3)
    ) dut (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (u_if)
    );

    // ctl = {hold_pc, hold_if_id, hold_id_ex, hold_ex_mem, flush_if_id, flush_id_ex, pc_jump}
    localparam logic [6:0] C_IDLE  = 7'b0000000;
    localparam logic [6:0] C_JUMP  = 7'b0000111;
    localparam logic [6:0] C_FLUSH = 7'b0000100;
    localparam logic [6:0] C_LU    = 7'b1100010;
    localparam logic [6:0] C_MEM   = 7'b1111000;

    typedef struct packed {
        logic [6:0]  ctl;
        logic [1:0]  st;
        logic [31:0] addr;
        logic        tmo;
    } obs_t;

    typedef struct packed {
        logic        jf;
        logic [31:0] ja;
        logic        risk;
        logic        mem;
        obs_t        exp;
    } step_t;

    obs_t  sb_q[$];
    int    n_tests;
    int    n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic step_t mk(input logic jf, input logic [31:0] ja, input logic risk,
                                 input logic mem, input logic [6:0] ctl, input logic [1:0] st,
                                 input logic [31:0] addr, input logic tmo);
        step_t s;
        s.jf = jf; s.ja = ja; s.risk = risk; s.mem = mem;
        s.exp.ctl = ctl; s.exp.st = st; s.exp.addr = addr; s.exp.tmo = tmo;
        return s;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.ctl  = {u_if.hold_pc_o, u_if.hold_if_id_o, u_if.hold_id_ex_o, u_if.hold_ex_mem_o,
                  u_if.flush_if_id_o, u_if.flush_id_ex_o, u_if.pc_jump_o};
        o.st   = u_if.state_o;
        o.addr = u_if.pc_jump_addr_o;
        o.tmo  = u_if.mem_timeout_o;
        return o;
    endfunction

    task automatic clear_inputs();
        u_if.jump_flag_i = 1'b0;
        u_if.jump_addr_i = 32'd0;
        u_if.hold_risk_i = 1'b0;
        u_if.hold_mem_i  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        arst_n = 1'b0;
        clear_inputs();
        @(negedge clk);
        arst_n = 1'b1;
    endtask

    // Drive one cycle of stimulus and record its expected response.
    task automatic apply(input step_t s);
        @(negedge clk);
        u_if.jump_flag_i = s.jf;
        u_if.jump_addr_i = s.ja;
        u_if.hold_risk_i = s.risk;
        u_if.hold_mem_i  = s.mem;
        sb_q.push_back(s.exp);
        #2;
    endtask

    task automatic test_reset();
        step_t steps[$];
        obs_t  got, exp;
        arst_n = 1'b0;
        u_if.jump_flag_i = 1'b1;
        u_if.jump_addr_i = 32'hDEAD_BEEF;
        u_if.hold_risk_i = 1'b1;
        u_if.hold_mem_i  = 1'b1;
        #3;
        got = sample();
        n_tests++;
        if (got !== {C_IDLE, 2'd0, 32'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_outputs: got ctl=%b st=%0d addr=%h tmo=%b, expected all 0",
                     got.ctl, got.st, got.addr, got.tmo);
        end
        @(negedge clk);
        clear_inputs();
        @(negedge clk);
        arst_n = 1'b1;
        for (int i = 0; i < 10; i++) steps.push_back(mk(1'b0, 32'd0, 1'b0, 1'b0, C_IDLE, 2'd0, 32'd0, 1'b0));
        foreach (steps[i]) begin
            apply(steps[i]);
            got = sample();
            exp = sb_q.pop_front();
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL reset_idle[%0d]: got ctl=%b st=%0d addr=%h tmo=%b, expected ctl=%b st=%0d addr=%h tmo=%b",
                         i, got.ctl, got.st, got.addr, got.tmo, exp.ctl, exp.st, exp.addr, exp.tmo);
            end
        end
        n_tests++;
        if (u_if.stall_cnt_o !== 32'd0 || u_if.redirect_cnt_o !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_counters: got stall=%0d redirect=%0d, expected 0 0",
                     u_if.stall_cnt_o, u_if.redirect_cnt_o);
        end
    endtask

    task automatic test_jump();
        step_t steps[$];
        obs_t  got, exp;
        do_reset();
        steps.push_back(mk(1'b1, 32'h0000_0100, 1'b0, 1'b0, C_JUMP,  2'd0, 32'h0000_0100, 1'b0));
        steps.push_back(mk(1'b0, 32'd0,         1'b0, 1'b0, C_FLUSH, 2'd1, 32'd0, 1'b0));
        steps.push_back(mk(1'b0, 32'd0,         1'b0, 1'b0, C_IDLE,  2'd0, 32'd0, 1'b0));
        steps.push_back(mk(1'b1, 32'h0000_0104, 1'b0, 1'b0, C_JUMP,  2'd0, 32'h0000_0104, 1'b0));
        steps.push_back(mk(1'b0, 32'd0,         1'b1, 1'b0, C_FLUSH, 2'd1, 32'd0, 1'b0));
        steps.push_back(mk(1'b0, 32'd0,         1'b0, 1'b0, C_IDLE,  2'd0, 32'd0, 1'b0));
        foreach (steps[i]) begin
            apply(steps[i]);
            got = sample();
            exp = sb_q.pop_front();
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL jump[%0d]: got ctl=%b st=%0d addr=%h tmo=%b, expected ctl=%b st=%0d addr=%h tmo=%b",
                         i, got.ctl, got.st, got.addr, got.tmo, exp.ctl, exp.st, exp.addr, exp.tmo);
            end
        end
        n_tests++;
        if (u_if.redirect_cnt_o !== 32'd2 || u_if.stall_cnt_o !== 32'd0) begin
            n_fail++;
            $display("FAIL jump_counters: got redirect=%0d stall=%0d, expected 2 0",
                     u_if.redirect_cnt_o, u_if.stall_cnt_o);
        end
    endtask

    task automatic test_load_use();
        step_t steps[$];
        obs_t  got, exp;
        do_reset();
        steps.push_back(mk(1'b0, 32'd0, 1'b1, 1'b0, C_LU,    2'd0, 32'd0, 1'b0));
        steps.push_back(mk(1'b0, 32'd0, 1'b0, 1'b0, C_LU,    2'd2, 32'd0, 1'b0));
        steps.push_back(mk(1'b0, 32'd0, 1'b0, 1'b0, C_IDLE,  2'd0, 32'd0, 1'b0));
        steps.push_back(mk(1'b0, 32'd0, 1'b1, 1'b0, C_LU,    2'd0, 32'd0, 1'b0));
        steps.push_back(mk(1'b0, 32'd0, 1'b1, 1'b0, C_LU,    2'd2, 32'd0, 1'b0));
        steps.push_back(mk(1'b0, 32'd0, 1'b1, 1'b0, C_LU,    2'd0, 32'd0, 1'b0));
        steps.push_back(mk(1'b0, 32'd0, 1'b0, 1'b0, C_LU,    2'd2, 32'd0, 1'b0));
        steps.push_back(mk(1'b0, 32'd0, 1'b0, 1'b0, C_IDLE,  2'd0, 32'd0, 1'b0));
        steps.push_back(mk(1'b0, 32'd0, 1'b1, 1'b0, C_LU,    2'd0, 32'd0, 1'b0));
        steps.push_back(mk(1'b1, 32'h0000_0300, 1'b0, 1'b0, C_JUMP, 2'd2, 32'h0000_0300, 1'b0));
        steps.push_back(mk(1'b0, 32'd0, 1'b0, 1'b0, C_FLUSH, 2'd1, 32'd0, 1'b0));
        steps.push_back(mk(1'b0, 32'd0, 1'b0, 1'b0, C_IDLE,  2'd0, 32'd0, 1'b0));
        foreach (steps[i]) begin
            apply(steps[i]);
            got = sample();
            exp = sb_q.pop_front();
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL load_use[%0d]: got ctl=%b st=%0d addr=%h tmo=%b, expected ctl=%b st=%0d addr=%h tmo=%b",
                         i, got.ctl, got.st, got.addr, got.tmo, exp.ctl, exp.st, exp.addr, exp.tmo);
            end
            if (i == 2) begin
                n_tests++;
                if (u_if.stall_cnt_o !== 32'd2) begin
                    n_fail++;
                    $display("FAIL load_use_stall_first: got %0d, expected 2", u_if.stall_cnt_o);
                end
            end
        end
        n_tests++;
        if (u_if.stall_cnt_o !== 32'd7 || u_if.redirect_cnt_o !== 32'd1) begin
            n_fail++;
            $display("FAIL load_use_counters: got stall=%0d redirect=%0d, expected 7 1",
                     u_if.stall_cnt_o, u_if.redirect_cnt_o);
        end
    endtask

    task automatic test_mem_hold();
        step_t steps[$];
        obs_t  got, exp;
        do_reset();
        steps.push_back(mk(1'b1, 32'h0000_0200, 1'b0, 1'b1, C_MEM, 2'd0, 32'd0, 1'b0));
        steps.push_back(mk(1'b1, 32'h0000_0200, 1'b1, 1'b1, C_MEM, 2'd0, 32'd0, 1'b0));
        steps.push_back(mk(1'b1, 32'h0000_0200, 1'b0, 1'b1, C_MEM, 2'd0, 32'd0, 1'b0));
        steps.push_back(mk(1'b1, 32'h0000_0200, 1'b0, 1'b1, C_MEM, 2'd0, 32'd0, 1'b1));
        steps.push_back(mk(1'b1, 32'h0000_0200, 1'b0, 1'b0, C_JUMP, 2'd0, 32'h0000_0200, 1'b1));
        steps.push_back(mk(1'b0, 32'd0, 1'b0, 1'b0, C_FLUSH, 2'd1, 32'd0, 1'b1));
        steps.push_back(mk(1'b0, 32'd0, 1'b0, 1'b0, C_IDLE,  2'd0, 32'd0, 1'b1));
        foreach (steps[i]) begin
            apply(steps[i]);
            got = sample();
            exp = sb_q.pop_front();
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL mem_hold[%0d]: got ctl=%b st=%0d addr=%h tmo=%b, expected ctl=%b st=%0d addr=%h tmo=%b",
                         i, got.ctl, got.st, got.addr, got.tmo, exp.ctl, exp.st, exp.addr, exp.tmo);
            end
        end
        n_tests++;
        if (u_if.stall_cnt_o !== 32'd4 || u_if.redirect_cnt_o !== 32'd1) begin
            n_fail++;
            $display("FAIL mem_hold_counters: got stall=%0d redirect=%0d, expected 4 1",
                     u_if.stall_cnt_o, u_if.redirect_cnt_o);
        end
    endtask

    task automatic test_timeout();
        step_t steps[$];
        obs_t  got, exp;
        do_reset();
        // Two short holds separated by a release must not accumulate.
        steps.push_back(mk(1'b0, 32'd0, 1'b0, 1'b1, C_MEM,  2'd0, 32'd0, 1'b0));
        steps.push_back(mk(1'b0, 32'd0, 1'b0, 1'b1, C_MEM,  2'd0, 32'd0, 1'b0));
        steps.push_back(mk(1'b0, 32'd0, 1'b0, 1'b0, C_IDLE, 2'd0, 32'd0, 1'b0));
        steps.push_back(mk(1'b0, 32'd0, 1'b0, 1'b1, C_MEM,  2'd0, 32'd0, 1'b0));
        steps.push_back(mk(1'b0, 32'd0, 1'b0, 1'b1, C_MEM,  2'd0, 32'd0, 1'b0));
        steps.push_back(mk(1'b0, 32'd0, 1'b0, 1'b0, C_IDLE, 2'd0, 32'd0, 1'b0));
        for (int k = 0; k < 5; k++)
            steps.push_back(mk(1'b0, 32'd0, 1'b0, 1'b1, C_MEM, 2'd0, 32'd0, (k >= 3) ? 1'b1 : 1'b0));
        for (int k = 0; k < 3; k++)
            steps.push_back(mk(1'b0, 32'd0, 1'b0, 1'b0, C_IDLE, 2'd0, 32'd0, 1'b1));
        foreach (steps[i]) begin
            apply(steps[i]);
            got = sample();
            exp = sb_q.pop_front();
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL timeout[%0d]: got ctl=%b st=%0d addr=%h tmo=%b, expected ctl=%b st=%0d addr=%h tmo=%b",
                         i, got.ctl, got.st, got.addr, got.tmo, exp.ctl, exp.st, exp.addr, exp.tmo);
            end
        end
        do_reset();
        #2;
        n_tests++;
        if (u_if.mem_timeout_o !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_cleared_by_reset: got %b, expected 0", u_if.mem_timeout_o);
        end
    endtask

    task automatic test_reset_mid();
        step_t steps[$];
        obs_t  got, exp;
        do_reset();
        steps.push_back(mk(1'b1, 32'h0000_0400, 1'b0, 1'b0, C_JUMP,  2'd0, 32'h0000_0400, 1'b0));
        steps.push_back(mk(1'b0, 32'd0,         1'b0, 1'b0, C_FLUSH, 2'd1, 32'd0, 1'b0));
        steps.push_back(mk(1'b0, 32'd0,         1'b1, 1'b0, C_LU,    2'd0, 32'd0, 1'b0));
        steps.push_back(mk(1'b0, 32'd0,         1'b0, 1'b0, C_LU,    2'd2, 32'd0, 1'b0));
        for (int i = 0; i < 4; i++) begin
            apply(steps[i]);
            got = sample();
            exp = sb_q.pop_front();
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL reset_mid[%0d]: got ctl=%b st=%0d addr=%h tmo=%b, expected ctl=%b st=%0d addr=%h tmo=%b",
                         i, got.ctl, got.st, got.addr, got.tmo, exp.ctl, exp.st, exp.addr, exp.tmo);
            end
            if (i == 1 || i == 3) begin
                // Abort mid-FLUSH / mid-BUBBLE with requests still active.
                u_if.jump_flag_i = 1'b1;
                u_if.jump_addr_i = 32'h0000_0500;
                arst_n = 1'b0;
                #1;
                got = sample();
                n_tests++;
                if (got !== {C_IDLE, 2'd0, 32'd0, 1'b0} || u_if.stall_cnt_o !== 32'd0 ||
                    u_if.redirect_cnt_o !== 32'd0) begin
                    n_fail++;
                    $display("FAIL reset_mid_abort[%0d]: got ctl=%b st=%0d addr=%h stall=%0d redirect=%0d, expected all 0",
                             i, got.ctl, got.st, got.addr, u_if.stall_cnt_o, u_if.redirect_cnt_o);
                end
                @(negedge clk);
                clear_inputs();
                arst_n = 1'b1;
            end
        end
        apply(mk(1'b0, 32'd0, 1'b0, 1'b0, C_IDLE, 2'd0, 32'd0, 1'b0));
        got = sample();
        exp = sb_q.pop_front();
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL reset_mid_exit: got ctl=%b st=%0d, expected ctl=%b st=%0d",
                     got.ctl, got.st, exp.ctl, exp.st);
        end
    endtask

    task automatic test_back_to_back();
        step_t steps[$];
        obs_t  got, exp;
        do_reset();
        steps.push_back(mk(1'b1, 32'h0000_1000, 1'b0, 1'b0, C_JUMP,  2'd0, 32'h0000_1000, 1'b0));
        steps.push_back(mk(1'b0, 32'd0,         1'b0, 1'b1, C_MEM,   2'd1, 32'd0, 1'b0));
        steps.push_back(mk(1'b0, 32'd0,         1'b0, 1'b1, C_MEM,   2'd1, 32'd0, 1'b0));
        steps.push_back(mk(1'b0, 32'd0,         1'b0, 1'b0, C_FLUSH, 2'd1, 32'd0, 1'b0));
        steps.push_back(mk(1'b0, 32'd0,         1'b0, 1'b0, C_IDLE,  2'd0, 32'd0, 1'b0));
        steps.push_back(mk(1'b1, 32'h0000_2000, 1'b1, 1'b0, C_JUMP,  2'd0, 32'h0000_2000, 1'b0));
        steps.push_back(mk(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, C_JUMP,  2'd1, 32'hFFFF_FFFC, 1'b0));
        steps.push_back(mk(1'b0, 32'd0,         1'b0, 1'b0, C_FLUSH, 2'd1, 32'd0, 1'b0));
        steps.push_back(mk(1'b0, 32'd0,         1'b1, 1'b0, C_LU,    2'd0, 32'd0, 1'b0));
        steps.push_back(mk(1'b0, 32'd0,         1'b0, 1'b1, C_MEM,   2'd2, 32'd0, 1'b0));
        steps.push_back(mk(1'b0, 32'd0,         1'b0, 1'b0, C_LU,    2'd2, 32'd0, 1'b0));
        steps.push_back(mk(1'b0, 32'd0,         1'b0, 1'b0, C_IDLE,  2'd0, 32'd0, 1'b0));
        foreach (steps[i]) begin
            apply(steps[i]);
            got = sample();
            exp = sb_q.pop_front();
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL back_to_back[%0d]: got ctl=%b st=%0d addr=%h tmo=%b, expected ctl=%b st=%0d addr=%h tmo=%b",
                         i, got.ctl, got.st, got.addr, got.tmo, exp.ctl, exp.st, exp.addr, exp.tmo);
            end
        end
        n_tests++;
        if (u_if.stall_cnt_o !== 32'd5 || u_if.redirect_cnt_o !== 32'd3) begin
            n_fail++;
            $display("FAIL back_to_back_counters: got stall=%0d redirect=%0d, expected 5 3",
                     u_if.stall_cnt_o, u_if.redirect_cnt_o);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_jump();
        test_load_use();
        test_mem_hold();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
